// File: rtl/event_blinker.sv
// ============================================================================
// event_blinker
//
// Turns single-cycle event strobes into fixed-length LED blinks.
//
// Each event produces one blink: ON_TIME cycles with the LED lit, followed by
// a forced OFF_TIME-cycle dark gap. Events that arrive while a blink is in
// progress are queued, up to 15 of them, and played back-to-back. An event
// that arrives while the queue is full is dropped, and the sticky overflow
// flag is raised.
//
// Parameters
//   ON_TIME    LED-on cycles per blink            (1 .. 2^24-1)
//   OFF_TIME   forced dark cycles between blinks  (1 .. 2^24-1)
//
// Ports
//   i_clk       single clock; all state changes on its rising edge
//   i_reset     synchronous, active-high; wins over everything else
//   i_event     one event per high cycle
//   i_clear     synchronous flush: abort blink, drop queue, clear overflow
//   o_led       registered LED drive
//   o_busy      high whenever the controller is not idle
//   o_pending   number of queued events not yet blinked (0..15)
//   o_overflow  sticky: at least one event was dropped
//   o_debug     {o_overflow, state[1:0], o_pending[3:0], o_led}
//
// All outputs come straight from flops (or from a compare on a flop), so
// there is no combinational path from any input to any output.
// ============================================================================
module event_blinker #(
    parameter int unsigned ON_TIME  = 'd4,
    parameter int unsigned OFF_TIME = 'd2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_event,
    input  logic       i_clear,
    output logic       o_led,
    output logic       o_busy,
    output logic [3:0] o_pending,
    output logic       o_overflow,
    output logic [7:0] o_debug
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2,
        ST_BAD  = 2'd3
    } state_t;

    // Timer reload values. The timer counts down to zero inclusive, so a
    // phase lasting N cycles is loaded with N-1.
    localparam logic [23:0] ON_LOAD  = 24'(ON_TIME - 1);
    localparam logic [23:0] OFF_LOAD = 24'(OFF_TIME - 1);

    localparam logic [3:0] PENDING_MAX = 4'd15;

    state_t      state_q,    state_d;
    logic [23:0] timer_q,    timer_d;
    logic        led_q,      led_d;
    logic [3:0]  pending_q,  pending_d;
    logic        overflow_q, overflow_d;

    logic        timer_zero;
    logic        start;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        led_d      = led_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;

        timer_zero = (timer_q == 24'd0);

        // A new blink may begin from idle, or on the last cycle of a gap so
        // that back-to-back blinks see exactly OFF_TIME dark cycles. The
        // demand is either a queued event or an event arriving right now,
        // which lets a fresh event skip the queue entirely.
        start = ((state_q == ST_IDLE) || ((state_q == ST_GAP) && timer_zero))
                && ((pending_q != 4'd0) || i_event);

        if (i_clear) begin
            // Flush wins over the current event, which is simply discarded.
            state_d    = ST_IDLE;
            timer_d    = 24'd0;
            led_d      = 1'b0;
            pending_d  = 4'd0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    led_d = 1'b0;
                    if (start) begin
                        state_d = ST_ON;
                        timer_d = ON_LOAD;
                        led_d   = 1'b1;
                    end
                end

                ST_ON: begin
                    led_d = 1'b1;
                    if (timer_zero) begin
                        state_d = ST_GAP;
                        timer_d = OFF_LOAD;
                        led_d   = 1'b0;
                    end else begin
                        timer_d = timer_q - 24'd1;
                    end
                end

                ST_GAP: begin
                    led_d = 1'b0;
                    if (start) begin
                        // Chain straight into the next blink without an
                        // idle cycle in between.
                        state_d = ST_ON;
                        timer_d = ON_LOAD;
                        led_d   = 1'b1;
                    end else if (timer_zero) begin
                        state_d = ST_IDLE;
                    end else begin
                        timer_d = timer_q - 24'd1;
                    end
                end

                default: begin
                    // Unused encoding: recover to idle on the next edge.
                    state_d = ST_IDLE;
                    timer_d = 24'd0;
                    led_d   = 1'b0;
                end
            endcase

            // Queue bookkeeping: pending + event - start. When both happen
            // in the same cycle the count is unchanged, which also covers
            // the case of an event consumed directly with an empty queue.
            if (i_event && !start) begin
                if (pending_q == PENDING_MAX) begin
                    overflow_d = 1'b1;
                end else begin
                    pending_d = pending_q + 4'd1;
                end
            end else if (!i_event && start) begin
                pending_d = pending_q - 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            timer_q    <= 24'd0;
            led_q      <= 1'b0;
            pending_q  <= 4'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            led_q      <= led_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_led      = led_q;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_pending  = pending_q;
    assign o_overflow = overflow_q;
    assign o_debug    = {overflow_q, state_q, pending_q, led_q};

endmodule

// File: doc/event_blinker.md
EVENT_BLINKER -- requirements
Module: event_blinker

Interface
REQ-001 SHALL have parameter ON_TIME, default 'd4: LED-on cycles per blink; legal range 1 to 2^24-1.
REQ-002 SHALL have parameter OFF_TIME, default 'd2: forced LED-off gap cycles between consecutive blinks; legal range 1 to 2^24-1.
REQ-003 SHALL have port i_clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_event  input  1  single-cycle event strobe, e.g. a debounced press pulse; each high cycle counts as one event.
REQ-006 SHALL have port i_clear  input  1  synchronous flush: aborts the blink, drops pending events, clears overflow.
REQ-007 SHALL have port o_led  output  1  registered LED drive.
REQ-008 SHALL have port o_busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port o_pending  output  4  queued events not yet blinked.
REQ-010 SHALL have port o_overflow  output  1  sticky flag: an event was dropped.
REQ-011 SHALL have port o_debug  output  8  {o_overflow, state[1:0], o_pending[3:0], o_led}.

Function
REQ-012 SHALL implement states IDLE=2'd0, ON=2'd1 and GAP=2'd2; encoding 2'd3 SHALL return to IDLE on the next cycle.
REQ-013 SHALL define "start" as: (IDLE, or GAP with timer==0) and (o_pending!=0 or i_event==1).
REQ-014 SHALL, on start, enter ON, load a 24-bit down-timer with ON_TIME-1 and drive o_led=1 from that edge; one-cycle latency from i_event in IDLE to o_led high.
REQ-015 SHALL, in ON with timer==0, enter GAP, load OFF_TIME-1 and drive o_led=0; o_led SHALL be high for exactly ON_TIME cycles per blink.
REQ-016 SHALL, in GAP with timer==0 and no start, enter IDLE; o_led low for exactly OFF_TIME cycles between back-to-back blinks.
REQ-017 SHALL otherwise decrement the timer by 1 each cycle in ON and GAP; the timer SHALL never wrap below 0.
REQ-018 SHALL update pending as pending + i_event - start; when i_event and start coincide, pending SHALL be unchanged.
REQ-019 SHALL consume the current-cycle i_event directly when starting with pending==0.
REQ-020 SHALL saturate pending at 15; an i_event arriving at 15 without a coincident start SHALL be dropped and SHALL set o_overflow.
REQ-021 SHALL hold o_overflow high until i_clear or i_reset.
REQ-022 SHALL, on i_clear, go to IDLE, clear the timer, o_led, pending and overflow on the next edge; an i_event in the same cycle SHALL be ignored.
REQ-023 SHALL give i_reset priority over i_clear and i_event.
REQ-024 SHALL drive all outputs from registers; there SHALL be no combinational path from input to output.

Reset
REQ-025 SHALL, on i_reset high at a clock edge, set state=IDLE, timer=0, o_led=0, o_busy=0, o_pending=0, o_overflow=0 and o_debug=8'h00.
REQ-026 SHALL, on reset mid-blink, drop the blink and pending events with no further o_led pulse.
REQ-027 SHALL leave i_event ignored while i_reset is high.

Verification (ON_TIME=4, OFF_TIME=2)
REQ-028 SHALL cover a single event: pulse at cycle N -> o_led high cycles N+1..N+4, o_busy high N+1..N+6, IDLE at N+7, o_pending stays 0.
REQ-029 SHALL cover three events on consecutive cycles: o_pending reads 1 then 2 -> three 4-cycle blinks separated by exactly 2 low cycles -> o_pending reaches 0 and o_overflow stays 0.
REQ-030 SHALL cover 20 events during one blink: o_pending saturates at 15 and o_overflow=1 -> 16 blinks total (1 active + 15 pending); o_overflow stays 1 afterward.
REQ-031 SHALL cover an event on the exact cycle GAP timer==0 with pending==0: o_led high on the next cycle, no IDLE visit, o_pending=0.
REQ-032 SHALL cover i_clear mid-ON with pending=5, overflow=1, and i_event high the same cycle: next cycle o_led=0, o_pending=0, o_overflow=0, o_busy=0.
REQ-033 SHALL cover i_reset asserted together with i_clear and i_event mid-blink: next cycle o_debug=8'h00, with no blink until a new event.
